wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 25 ++
 rtl/wb_stage.sv | 123 ++++++++++++
 tb/tb_wb_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bundle: valid/allowin plus the instruction fields carried with valid.
// A transfer happens on any rising edge where ms_to_ws_valid && ws_allowin; fields are only meaningful while valid is high.
interface wb_stage_if;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result;
    logic [2:0]  ms_ld_op;
    logic [1:0]  ms_addr_lo;
    logic [31:0] ms_mem_rdata;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_alu_result,
               ms_ld_op, ms_addr_lo, ms_mem_rdata,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_alu_result,
               ms_ld_op, ms_addr_lo, ms_mem_rdata,
        output ws_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction, extracts load data, drives the register-file
// write port, the decode bypass, the commit trace and a retired-instruction counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    wb_stage_if.slave   ms,
    input  logic        flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ws_fwd_valid,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] retire_cnt
);

    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_W  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b101;
    localparam logic [2:0] LD_HU = 3'b110;

    logic        ws_valid;
    logic        ws_ready_go;
    logic [31:0] ws_pc;
    logic        ws_gr_we;
    logic [4:0]  ws_dest;
    logic [31:0] ws_alu_result;
    logic [2:0]  ws_ld_op;
    logic [1:0]  ws_addr_lo;
    logic [31:0] ws_mem_rdata;
    logic [31:0] retire_cnt_q;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] final_result;
    logic        ws_writes_gr;

    // WB always finishes in one cycle, so it never back-pressures MEM.
    assign ws_ready_go  = 1'b1;
    assign ms.ws_allowin = !ws_valid || ws_ready_go;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ws_valid      <= 1'b0;
            ws_pc         <= 32'd0;
            ws_gr_we      <= 1'b0;
            ws_dest       <= 5'd0;
            ws_alu_result <= 32'd0;
            ws_ld_op      <= 3'd0;
            ws_addr_lo    <= 2'd0;
            ws_mem_rdata  <= 32'd0;
            retire_cnt_q  <= 32'd0;
        end else begin
            // A flush cancels the resident instruction and wins over a new arrival.
            if (flush) begin
                ws_valid <= 1'b0;
            end else if (ms.ws_allowin) begin
                ws_valid <= ms.ms_to_ws_valid;
            end

            if (ms.ms_to_ws_valid && ms.ws_allowin) begin
                ws_pc         <= ms.ms_pc;
                ws_gr_we      <= ms.ms_gr_we;
                ws_dest       <= ms.ms_dest;
                ws_alu_result <= ms.ms_alu_result;
                ws_ld_op      <= ms.ms_ld_op;
                ws_addr_lo    <= ms.ms_addr_lo;
                ws_mem_rdata  <= ms.ms_mem_rdata;
            end

            if (ws_valid && !flush) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        ld_byte = ws_mem_rdata[7:0];
        case (ws_addr_lo)
            2'd0:    ld_byte = ws_mem_rdata[7:0];
            2'd1:    ld_byte = ws_mem_rdata[15:8];
            2'd2:    ld_byte = ws_mem_rdata[23:16];
            default: ld_byte = ws_mem_rdata[31:24];
        endcase

        // Halfword select ignores addr_lo[0]; misalignment is handled upstream.
        ld_half = ws_addr_lo[1] ? ws_mem_rdata[31:16] : ws_mem_rdata[15:0];

        final_result = ws_alu_result;
        case (ws_ld_op)
            LD_B:    final_result = {{24{ld_byte[7]}}, ld_byte};
            LD_H:    final_result = {{16{ld_half[15]}}, ld_half};
            LD_W:    final_result = ws_mem_rdata;
            LD_BU:   final_result = {24'd0, ld_byte};
            LD_HU:   final_result = {16'd0, ld_half};
            default: final_result = ws_alu_result;
        endcase
    end

    assign ws_writes_gr = ws_valid && ws_gr_we && (ws_dest != 5'd0);

    assign rf_we    = ws_writes_gr && !flush;
    assign rf_waddr = ws_dest;
    assign rf_wdata = final_result;

    // Bypass is not gated by flush; decode is cancelled by the same flush.
    assign ws_fwd_valid = ws_writes_gr;
    assign ws_fwd_dest  = ws_dest;
    assign ws_fwd_data  = final_result;

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_dest;
    assign debug_wb_rf_wdata = final_result;

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load extraction, handshake, flush, counter wrap and reset.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] retire_cnt;

    int pass_cnt;
    int total_cnt;

    wb_stage_if ms_if ();

    wb_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ms                (ms_if.slave),
        .flush             (flush),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_valid      (ws_fwd_valid),
        .ws_fwd_dest       (ws_fwd_dest),
        .ws_fwd_data       (ws_fwd_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retire_cnt        (retire_cnt)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                           input logic [31:0] alu, input logic [2:0] ld_op,
                           input logic [1:0] addr_lo, input logic [31:0] rdata);
        ms_if.ms_to_ws_valid = 1'b1;
        ms_if.ms_pc          = pc;
        ms_if.ms_gr_we       = gr_we;
        ms_if.ms_dest        = dest;
        ms_if.ms_alu_result  = alu;
        ms_if.ms_ld_op       = ld_op;
        ms_if.ms_addr_lo     = addr_lo;
        ms_if.ms_mem_rdata   = rdata;
    endtask

    task automatic idle();
        ms_if.ms_to_ws_valid = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        present(32'h0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0);
        idle();
        @(negedge clk);
        step();

        check("rst_allowin", {31'd0, ms_if.ws_allowin}, 32'd1);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
        check("rst_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        check("rst_dbg_pc", debug_wb_pc, 32'd0);

        rst_n = 1'b1;
        step();
        check("idle_retire", retire_cnt, 32'd0);

        // ld.b, byte 2 of 0x12F45678 = 0xF4
        present(32'h1C00_0000, 1'b1, 5'd5, 32'h0000_DEAD, 3'b001, 2'd2, 32'h12F4_5678);
        step();
        check("ldb_rf_we", {31'd0, rf_we}, 32'd1);
        check("ldb_rf_waddr", {27'd0, rf_waddr}, 32'd5);
        check("ldb_rf_wdata", rf_wdata, 32'hFFFF_FFF4);
        check("ldb_fwd_valid", {31'd0, ws_fwd_valid}, 32'd1);
        check("ldb_fwd_data", ws_fwd_data, 32'hFFFF_FFF4);
        check("ldb_dbg_pc", debug_wb_pc, 32'h1C00_0000);
        check("ldb_dbg_we", {28'd0, debug_wb_rf_we}, 32'hF);
        check("ldb_retire", retire_cnt, 32'd0);

        present(32'h1C00_0004, 1'b1, 5'd6, 32'h0, 3'b110, 2'd2, 32'h8001_ABCD);
        step();
        check("ldhu_wdata", rf_wdata, 32'h0000_8001);
        check("ldhu_retire", retire_cnt, 32'd1);

        present(32'h1C00_0008, 1'b1, 5'd6, 32'h0, 3'b010, 2'd2, 32'h8001_ABCD);
        step();
        check("ldh_wdata", rf_wdata, 32'hFFFF_8001);
        check("ldh_retire", retire_cnt, 32'd2);

        present(32'h1C00_000C, 1'b1, 5'd9, 32'h0, 3'b101, 2'd3, 32'hA500_1234);
        step();
        check("ldbu_wdata", rf_wdata, 32'h0000_00A5);

        // ld_op 100 is not a load: alu_result passes through
        present(32'h1C00_0010, 1'b1, 5'd10, 32'h1234_5678, 3'b100, 2'd0, 32'hFFFF_FFFF);
        step();
        check("ldop100_wdata", rf_wdata, 32'h1234_5678);
        check("ldop100_retire", retire_cnt, 32'd4);

        present(32'h1C00_0014, 1'b1, 5'd0, 32'h0000_0055, 3'b000, 2'd0, 32'h0);
        step();
        check("r0_rf_we", {31'd0, rf_we}, 32'd0);
        check("r0_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
        check("r0_wdata", rf_wdata, 32'h0000_0055);
        check("r0_retire_before", retire_cnt, 32'd5);
        idle();
        step();
        check("r0_retire_after", retire_cnt, 32'd6);
        check("r0_after_rf_we", {31'd0, rf_we}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            present(32'h0000_0100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h0000_1000 + 32'(i),
                    3'b000, 2'd0, 32'h0);
            check("b2b_allowin", {31'd0, ms_if.ws_allowin}, 32'd1);
            step();
            check("b2b_dbg_pc", debug_wb_pc, 32'h0000_0100 + 32'(4 * i));
            check("b2b_dbg_wnum", {27'd0, debug_wb_rf_wnum}, 32'(i + 1));
            check("b2b_dbg_wdata", debug_wb_rf_wdata, 32'h0000_1000 + 32'(i));
            check("b2b_dbg_we", {28'd0, debug_wb_rf_we}, 32'hF);
            check("b2b_retire", retire_cnt, 32'd6 + 32'(i));
        end
        idle();
        step();
        check("b2b_retire_total", retire_cnt, 32'd10);

        // Flush while a ld.w to r7 is resident
        present(32'h1C00_0040, 1'b1, 5'd7, 32'h0, 3'b011, 2'd0, 32'hCAFE_BABE);
        step();
        idle();
        check("ldw_wdata", rf_wdata, 32'hCAFE_BABE);
        flush = 1'b1;
        #1;
        check("flush_rf_we", {31'd0, rf_we}, 32'd0);
        check("flush_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush_next_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
        check("flush_next_rf_we", {31'd0, rf_we}, 32'd0);
        check("flush_retire", retire_cnt, 32'd10);

        // Flush coinciding with an arrival: the arrival is dropped
        present(32'h1C00_0044, 1'b1, 5'd7, 32'h0, 3'b011, 2'd0, 32'h1111_2222);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        #1;
        check("flush_cap_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
        step();
        check("flush_cap_retire", retire_cnt, 32'd10);

        // Counter wrap: preload 0xFFFFFFFF while an instruction is resident
        present(32'h1C00_0050, 1'b1, 5'd3, 32'h0000_0033, 3'b000, 2'd0, 32'h0);
        step();
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        check("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
        present(32'h1C00_0054, 1'b1, 5'd4, 32'h0000_0044, 3'b000, 2'd0, 32'h0);
        step();
        idle();
        check("wrap_retire", retire_cnt, 32'd0);
        check("pre_rst_rf_we", {31'd0, rf_we}, 32'd1);

        // Reset with an instruction resident
        rst_n = 1'b0;
        step();
        check("rst2_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst2_fwd_valid", {31'd0, ws_fwd_valid}, 32'd0);
        check("rst2_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);
        check("rst2_allowin", {31'd0, ms_if.ws_allowin}, 32'd1);
        check("rst2_retire", retire_cnt, 32'd0);
        check("rst2_dbg_pc", debug_wb_pc, 32'd0);
        check("rst2_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_rf_we", {31'd0, rf_we}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
